// File: rtl/program_loader.sv
// Program loader: freezes the CPU, takes the shared bus and writes a byte stream
// into RAM as MAR/RAM strobe pairs, then pulses a CPU reset so execution restarts at 0.
module program_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  cpu_hold,
    output logic                  cpu_rst,
    output logic                  bus_drive,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  mar_read_from_bus,
    output logic                  ram_read_from_bus,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   load_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT_BYTE,
        S_ADDR,
        S_DATA,
        S_RELEASE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    // State advances on the falling edge, in step with the control unit's step
    // counter, so every strobe is settled before the datapath's rising edge.
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        byte_d            = byte_q;
        last_d            = last_q;
        count_d           = count_q;
        in_ready          = 1'b0;
        cpu_hold          = 1'b0;
        cpu_rst           = 1'b0;
        bus_drive         = 1'b0;
        bus_out           = '0;
        mar_read_from_bus = 1'b0;
        ram_read_from_bus = 1'b0;
        done              = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_HOLD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end

            S_HOLD: begin
                cpu_hold = 1'b1;
                state_d  = S_WAIT_BYTE;
            end

            S_WAIT_BYTE: begin
                cpu_hold = 1'b1;
                in_ready = 1'b1;
                // Abort wins over a same-cycle handshake; that byte is dropped.
                if (load_abort) begin
                    state_d = S_RELEASE;
                end else if (in_valid) begin
                    byte_d  = in_data;
                    last_d  = in_last;
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                cpu_hold          = 1'b1;
                bus_drive         = 1'b1;
                bus_out           = DATA_WIDTH'(addr_q);
                mar_read_from_bus = 1'b1;
                state_d           = S_DATA;
            end

            S_DATA: begin
                cpu_hold          = 1'b1;
                bus_drive         = 1'b1;
                bus_out           = byte_q;
                ram_read_from_bus = 1'b1;
                count_d           = count_q + COUNT_ONE;
                // The last address ends the session; the address never wraps.
                if (last_q || (addr_q == ADDR_LAST) || load_abort) begin
                    state_d = S_RELEASE;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_WAIT_BYTE;
                end
            end

            S_RELEASE: begin
                cpu_hold = 1'b1;
                cpu_rst  = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign load_count = count_q;

endmodule

// File: doc/program_loader.md
# program_loader

Bus-sharing controller that loads a program into the 16-byte RAM from an external byte stream (switches or UART front end) while the CPU is frozen. It holds the CPU via `clk_halt`, takes ownership of the shared 8-bit bus, sequences one MAR write then one RAM write per byte, and finally pulses a CPU reset so execution restarts from address 0. It sits beside `control` and arbitrates bus and RAM/MAR strobes between the two.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: RAM address width; a session loads at most 2^ADDR_WIDTH bytes.
- `DATA_WIDTH`, default 8: bus and byte width.

Ports:
- `clk`  in  1  system clock; the datapath latches on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `load_start`  in  1  level or pulse; starts a session when sampled high in IDLE.
- `load_abort`  in  1  ends the session early without writing further bytes.
- `in_valid`  in  1  a byte is offered on `in_data`.
- `in_data`  in  DATA_WIDTH  byte to store.
- `in_last`  in  1  marks the offered byte as the final one.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `cpu_hold`  out  1  ORed into `clk_halt`; CPU frozen while high.
- `cpu_rst`  out  1  one-cycle reset pulse to `control` and PC at session end.
- `bus_drive`  out  1  loader owns the bus; all other bus drivers must be off.
- `bus_out`  out  DATA_WIDTH  value driven on the bus when `bus_drive` is high, else 0.
- `mar_read_from_bus`  out  1  ORed with the control unit's MAR strobe.
- `ram_read_from_bus`  out  1  RAM write strobe (RAM latches bus).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a session completes or aborts.
- `load_count`  out  ADDR_WIDTH+1  bytes written in the current or last session.

## Operation
- All state updates occur on the falling edge of `clk`, matching the control unit's step counter, so strobes are stable before the datapath's rising edge.
- States: IDLE, HOLD, WAIT_BYTE, ADDR, DATA, RELEASE.
- IDLE: all outputs 0 except `load_count` (held). When `load_start` is high, go to HOLD, clear the address and `load_count`.
- HOLD: `cpu_hold`=1 for one cycle so any in-flight CPU step finishes its strobes. Then go to WAIT_BYTE.
- WAIT_BYTE: `in_ready`=1.
  - On `in_valid`&&`in_ready`, capture `in_data` and `in_last`, then go to ADDR.
  - If `load_abort` is high, go to RELEASE; abort takes priority over a simultaneous handshake, and that byte is not written.
- ADDR: `bus_drive`=1, `bus_out`={0, addr}, `mar_read_from_bus`=1. Go to DATA.
- DATA: `bus_drive`=1, `bus_out`=captured byte, `ram_read_from_bus`=1, `load_count`++ on exit.
  - If the captured `in_last` was set, or addr==2^ADDR_WIDTH-1, or `load_abort` is high, go to RELEASE.
  - Otherwise addr++ and go to WAIT_BYTE.
- RELEASE: `cpu_hold`=1, `cpu_rst`=1, `done`=1 for exactly one cycle, then IDLE.
- `cpu_hold` is 1 in HOLD, WAIT_BYTE, ADDR, DATA and RELEASE.
- `load_start` while `busy` is ignored. `in_valid` outside WAIT_BYTE is ignored.
- The address never wraps. The byte at the last address ends the session even without `in_last`.
- `load_abort` in ADDR does not cancel the pending DATA write: a byte is either fully written or not written at all.

## Timing
- Reset values: state IDLE; every output 0; `load_count`=0; internal address 0.
- Reset mid-session: on the next falling edge, bus and strobes are released and `cpu_hold` drops. No `cpu_rst` or `done` pulse is produced.
- Start latency: `load_start` sampled, then HOLD for 1 cycle, then `in_ready` high on the 2nd cycle.
- Per byte: 3 cycles minimum (WAIT_BYTE, ADDR, DATA). `in_ready` is low during ADDR and DATA.
- A full 16-byte back-to-back load takes 1 (HOLD) + 48 + 1 (RELEASE) = 50 cycles from start to `done`.
- `bus_drive` is never high in the same cycle as `cpu_hold`=0.
- `mar_read_from_bus` and `ram_read_from_bus` are never high in the same cycle.

## Test plan
- Reset then idle: all outputs 0. Pulse `load_start` → `cpu_hold`=1 next cycle, `in_ready`=1 one cycle later.
- Load 3 bytes 0x1E, 0x2F, 0xE0 with `in_last` on the 3rd → RAM[0..2] holds those bytes, `load_count`=3, one `done` and one `cpu_rst` pulse, then `busy`=0.
- Stream 16 bytes back-to-back with `in_last` never set → session ends after address 15, `load_count`=16, `done` exactly 50 cycles after start.
- Hold `in_valid` low for 10 cycles mid-session → loader stalls in WAIT_BYTE with `cpu_hold`=1 and no strobes, then resumes at the correct address.
- Assert `load_abort` together with `in_valid` on the 2nd byte → only byte 0 written, `load_count`=1, `done` pulses.
- Assert `rst` during DATA of byte 4 → all outputs 0 on the next edge, no `cpu_rst`, `load_count`=0. A subsequent `load_start` restarts at address 0.
